// File: rtl/banco_reg_param_if.sv
// Register-file access bundle: two combinational read ports, one write port and
// the sweep/refusal status flags.
interface banco_reg_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              busy;
  logic              wr_err;

  modport master (
    output rd_addr1, rd_addr2, wr_addr, wr_data, wr_en,
    input  rd_data1, rd_data2, busy, wr_err
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_addr, wr_data, wr_en,
    output rd_data1, rd_data2, busy, wr_err
  );
endinterface

// File: rtl/banco_reg_param.sv
// Parameterised 2R1W register file. After reset it sweeps every entry to zero
// (busy high, writes refused), then serves reads with optional write forwarding.
module banco_reg_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic              clk,
  input logic              rst,
  banco_reg_param_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              wr_err_q, wr_err_d;
  logic              clr_c;
  logic              wr_ok_c;
  logic [DATA_W-1:0] rd_data1_c, rd_data2_c;
  logic [DATA_W-1:0] regs [DEPTH];

  // State, sweep pointer and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      busy_q   <= 1'b1;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Next-state logic; a write is accepted only in READY, outside reset, and not to a hardwired zero.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_err_d = 1'b0;
    clr_c    = 1'b0;
    wr_ok_c  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_c    = 1'b1;
        wr_err_d = bus.wr_en;
        ptr_d    = ADDR_W'(ptr_q + 1'b1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        wr_ok_c = !rst && bus.wr_en && !(ZERO_REG && bus.wr_addr == '0);
      end
      default: state_d = CLEAR;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // Storage: sweep clears take the write port while busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_c) begin
        regs[ptr_q] <= '0;
      end else if (wr_ok_c) begin
        regs[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Read port 1: forward same-cycle write, then force zero when busy or reading r0.
  always_comb begin
    rd_data1_c = regs[bus.rd_addr1];
    if (BYPASS && wr_ok_c && bus.wr_addr == bus.rd_addr1) rd_data1_c = bus.wr_data;
    if (busy_q || (ZERO_REG && bus.rd_addr1 == '0)) rd_data1_c = '0;
  end

  always_comb begin
    rd_data2_c = regs[bus.rd_addr2];
    if (BYPASS && wr_ok_c && bus.wr_addr == bus.rd_addr2) rd_data2_c = bus.wr_data;
    if (busy_q || (ZERO_REG && bus.rd_addr2 == '0)) rd_data2_c = '0;
  end

  assign bus.rd_data1 = rd_data1_c;
  assign bus.rd_data2 = rd_data2_c;
  assign bus.busy     = busy_q;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_banco_reg_param.sv
// Scoreboard bench: three register-file configurations share one random/directed
// stimulus stream and are checked against an array-based reference model.
module tb_banco_reg_param;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  banco_reg_param_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
  banco_reg_param_if #(.DATA_W(32), .ADDR_W(5)) ifb ();
  banco_reg_param_if #(.DATA_W(8),  .ADDR_W(3)) ifc ();

  assign ifb.rd_addr1 = ifa.rd_addr1;
  assign ifb.rd_addr2 = ifa.rd_addr2;
  assign ifb.wr_addr  = ifa.wr_addr;
  assign ifb.wr_data  = ifa.wr_data;
  assign ifb.wr_en    = ifa.wr_en;
  assign ifc.rd_addr1 = ifa.rd_addr1[2:0];
  assign ifc.rd_addr2 = ifa.rd_addr2[2:0];
  assign ifc.wr_addr  = ifa.wr_addr[2:0];
  assign ifc.wr_data  = ifa.wr_data[7:0];
  assign ifc.wr_en    = ifa.wr_en;

  banco_reg_param dut_a (.clk(clk), .rst(rst), .bus(ifa));
  banco_reg_param #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  banco_reg_param #(.DATA_W(8), .ADDR_W(3)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct packed {
    logic [2:0]  busy;
    logic [2:0]  werr;
    logic [95:0] r1;
    logic [95:0] r2;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem [3][32];
  int          left [3];
  logic        werr [3];
  logic [31:0] act_busy [3], act_werr [3], act_r1 [3], act_r2 [3];

  // Configurations: 0 = defaults, 1 = no zero reg / no bypass, 2 = 8-bit x 8 entries.
  function automatic int dep(input int c);
    return (c == 2) ? 8 : 32;
  endfunction

  function automatic logic [31:0] dmask(input int c);
    return (c == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic bit zr(input int c);
    return c != 1;
  endfunction

  function automatic bit byp(input int c);
    return c != 1;
  endfunction

  function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a, input logic r,
                                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
    int aa;
    int wi;
    aa = int'(a) % dep(c);
    wi = int'(wa) % dep(c);
    if (left[c] != 0) return 32'h0;
    if (zr(c) && aa == 0) return 32'h0;
    if (byp(c) && we && !r && wi == aa) return wd & dmask(c);
    return mem[c][aa];
  endfunction

  // Effect of one rising edge: reset restarts a DEPTH-cycle blackout after which everything is zero.
  task automatic model_edge(input int c, input logic r, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd);
    int wi;
    wi = int'(wa) % dep(c);
    if (r) begin
      left[c] = dep(c);
      werr[c] = 1'b0;
    end else if (left[c] != 0) begin
      werr[c] = we;
      left[c] = left[c] - 1;
      if (left[c] == 0)
        for (int i = 0; i < 32; i++) mem[c][i] = 32'h0;
    end else begin
      werr[c] = 1'b0;
      if (we && !(zr(c) && wi == 0)) mem[c][wi] = wd & dmask(c);
    end
  endtask

  task automatic cyc(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra1, input logic [4:0] ra2);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    ifa.wr_en    = we;
    ifa.wr_addr  = wa;
    ifa.wr_data  = wd;
    ifa.rd_addr1 = ra1;
    ifa.rd_addr2 = ra2;
    for (int c = 0; c < 3; c++) begin
      e.busy[c]       = (left[c] != 0);
      e.werr[c]       = werr[c];
      e.r1[c*32 +: 32] = exp_rd(c, ra1, r, we, wa, wd);
      e.r2[c*32 +: 32] = exp_rd(c, ra2, r, we, wa, wd);
    end
    q.push_back(e);
    for (int c = 0; c < 3; c++) model_edge(c, r, we, wa, wd);
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%h expected=%h at %0t", nm, c, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      act_busy[0] = 32'(ifa.busy);   act_busy[1] = 32'(ifb.busy);   act_busy[2] = 32'(ifc.busy);
      act_werr[0] = 32'(ifa.wr_err); act_werr[1] = 32'(ifb.wr_err); act_werr[2] = 32'(ifc.wr_err);
      act_r1[0] = ifa.rd_data1; act_r1[1] = ifb.rd_data1; act_r1[2] = {24'h0, ifc.rd_data1};
      act_r2[0] = ifa.rd_data2; act_r2[1] = ifb.rd_data2; act_r2[2] = {24'h0, ifc.rd_data2};
      for (int c = 0; c < 3; c++) begin
        chk("busy",     c, act_busy[c], 32'(mon_e.busy[c]));
        chk("wr_err",   c, act_werr[c], 32'(mon_e.werr[c]));
        chk("rd_data1", c, act_r1[c],   mon_e.r1[c*32 +: 32]);
        chk("rd_data2", c, act_r2[c],   mon_e.r2[c*32 +: 32]);
      end
    end
  end

  initial begin
    logic [4:0]  wa;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    rst          = 1'b1;
    ifa.wr_en    = 1'b0;
    ifa.wr_addr  = '0;
    ifa.wr_data  = '0;
    ifa.rd_addr1 = '0;
    ifa.rd_addr2 = '0;
    for (int c = 0; c < 3; c++) begin
      left[c] = dep(c);
      werr[c] = 1'b0;
      for (int i = 0; i < 32; i++) mem[c][i] = 32'h0;
    end
    repeat (2) @(posedge clk);

    // Reset pulse, sweep with a refused write at sweep cycle 5.
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 40; i++)
      cyc(1'b0, i == 5, 5'd9, 32'hCAFE_0009, 5'(i), 5'd9);

    // Every address reads zero after the sweep.
    for (int i = 0; i < 32; i++)
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

    cyc(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

    // Forwarding versus old value.
    cyc(1'b0, 1'b1, 5'd3, 32'h1111_1111, 5'd0, 5'd0);
    cyc(1'b0, 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd3);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);

    // Register 0 behaviour.
    cyc(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    cyc(1'b0, 1'b1, 5'd7, 32'h0000_00A5, 5'd7, 5'd7);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

    // Reset from READY, then reassert mid-sweep at cycle 10.
    cyc(1'b0, 1'b1, 5'd4, 32'hAAAA_5555, 5'd4, 5'd4);
    cyc(1'b1, 1'b1, 5'd5, 32'h5555_AAAA, 5'd4, 5'd5);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd7);
    cyc(1'b1, 1'b1, 5'd6, 32'h0BAD_0006, 5'd4, 5'd6);
    for (int i = 0; i < 40; i++)
      cyc(1'b0, i == 3, 5'd4, 32'h0000_1234, 5'd4, 5'd7);

    // Random traffic with occasional resets and deliberate read/write address collisions.
    for (int i = 0; i < 500; i++) begin
      wa  = 5'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      cyc($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), wa, $urandom, ra1, ra2);
    end

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0 pending entries", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/banco_reg_param.md
BANCO_REG_PARAM -- requirements
Module: banco_reg_param

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits (1..64).
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary.
REQ-004 Parameter BYPASS, default 1: 1 = write-to-read forwarding enabled; 0 = disabled.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rd_addr1  input  ADDR_W  read port 1 address.
REQ-008 rd_addr2  input  ADDR_W  read port 2 address.
REQ-009 rd_data1  output  DATA_W  read port 1 data, combinational.
REQ-010 rd_data2  output  DATA_W  read port 2 data, combinational.
REQ-011 wr_addr  input  ADDR_W  write address.
REQ-012 wr_data  input  DATA_W  write data.
REQ-013 wr_en  input  1  write enable.
REQ-014 busy  output  1  high while the clear sweep is running; writes are refused.
REQ-015 wr_err  output  1  registered one-cycle pulse flagging a refused write.

Function
REQ-016 The block SHALL have two states, CLEAR and READY, plus a sweep pointer ptr of ADDR_W bits.
REQ-017 In CLEAR with rst=0, each cycle SHALL write 0 to register ptr and increment ptr.
REQ-018 When ptr = DEPTH-1 in CLEAR, that cycle SHALL clear the last register and move to READY.
REQ-019 busy SHALL be 1 in CLEAR and 0 in READY; it falls exactly DEPTH cycles after rst deasserts.
REQ-020 In READY, wr_en=1 SHALL write wr_data to register wr_addr on the rising edge.
REQ-021 When ZERO_REG=1, writes with wr_addr=0 SHALL be dropped silently, with no wr_err.
REQ-022 wr_en=1 while busy=1 SHALL be dropped and SHALL set wr_err=1 on the next cycle; otherwise wr_err is 0 next cycle.
REQ-023 Read data SHALL equal the stored register contents, with no clock latency.
REQ-024 rd_data SHALL be 0 whenever busy=1, regardless of address.
REQ-025 When ZERO_REG=1 and rd_addr=0, rd_data SHALL be 0.
REQ-026 Forwarding: with BYPASS=1, READY, wr_en=1, wr_addr=rd_addr and the write not dropped, rd_data SHALL equal wr_data in the same cycle.
REQ-027 Forwarding SHALL apply to both read ports independently; with BYPASS=0 reads show the old value until after the edge.
REQ-028 Both read ports SHALL be able to read the same address simultaneously and return identical data.
REQ-029 The block SHALL NOT load memory contents from a file at initialisation.

Reset
REQ-030 While rst=1 the block SHALL hold state=CLEAR, ptr=0, busy=1 and wr_err=0; register contents are don't-care.
REQ-031 rst asserted mid-sweep SHALL restart the sweep from ptr=0; rst in READY SHALL start a full sweep.
REQ-032 rst=1 SHALL take priority over wr_en on the same edge, so no write occurs.

Verification
REQ-033 Defaults: pulse rst for 1 cycle, then count cycles until busy falls -> busy low exactly 32 cycles after rst falls; every address reads 0.
REQ-034 Write 0xDEADBEEF to address 7 in READY; read on both ports next cycle -> both return 0xDEADBEEF.
REQ-035 Drive wr_en=1, wr_addr=3 and rd_addr1=3 with wr_data=0x12345678 in the same cycle -> rd_data1 = 0x12345678 before the edge when BYPASS=1, and the old value when BYPASS=0.
REQ-036 Write 0xFFFFFFFF to address 0 with ZERO_REG=1 -> reads return 0 and wr_err stays 0; with ZERO_REG=0 -> reads return 0xFFFFFFFF.
REQ-037 Write during the sweep at cycle 5 after reset -> wr_err=1 for exactly one cycle; the target reads 0 after the sweep.
REQ-038 Reassert rst at sweep cycle 10, then release it -> busy stays high 32 more cycles; registers written before the reset read 0.
REQ-039 DATA_W=8, ADDR_W=3: sweep lasts 8 cycles; writing 0xA5 to address 7 reads back 0xA5.
